// File: rtl/register_access_arbiter.sv
// register_access_arbiter: round-robin, password-checked write arbiter for the left/right register pair
module register_access_arbiter #(
   parameter int MAX_FAILS = 3,
   parameter int LOCK_CYCLES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] system_password,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       sel_a,
   input  logic       sel_b,
   input  logic [3:0] pass_a,
   input  logic [3:0] pass_b,
   input  logic [3:0] data_a,
   input  logic [3:0] data_b,
   output logic       en_left,
   output logic       en_right,
   output logic [3:0] data_to_save,
   output logic       ack_a,
   output logic       ack_b,
   output logic       nack_a,
   output logic       nack_b,
   output logic       locked
);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, CHECK, WRITE, REJECT, LOCKOUT} state_t;
   state_t state, state_nx;
   logic ptr, gnt, sel_q, win_b;
   logic [3:0] pass_q, data_q;
   logic [FW-1:0] fails;
   logic [LW-1:0] lock_cnt;
   assign win_b = req_b & (~req_a | ptr);
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (req_a | req_b) ? CHECK : IDLE;
         CHECK:   state_nx = (pass_q == system_password) ? WRITE : REJECT;
         WRITE:   state_nx = IDLE;
         REJECT:  state_nx = (fails == FW'(MAX_FAILS)) ? LOCKOUT : IDLE;
         LOCKOUT: state_nx = (lock_cnt == '0) ? IDLE : LOCKOUT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ptr <= 1'b0;
         gnt <= 1'b0;
         sel_q <= 1'b0;
         pass_q <= '0;
         data_q <= '0;
         fails <= '0;
         lock_cnt <= '0;
      end else begin
         if (state == IDLE && (req_a | req_b)) begin
            gnt <= win_b;
            ptr <= ~win_b;
            sel_q <= win_b ? sel_b : sel_a;
            pass_q <= win_b ? pass_b : pass_a;
            data_q <= win_b ? data_b : data_a;
         end
         if (state == CHECK)
            fails <= (pass_q == system_password) ? '0 :
                     (fails == FW'(MAX_FAILS)) ? fails : fails + FW'(1);
         if (state == REJECT) lock_cnt <= LW'(LOCK_CYCLES - 1);
         if (state == LOCKOUT) begin
            lock_cnt <= lock_cnt - LW'(1);
            if (lock_cnt == '0) fails <= '0;
         end
      end
   assign en_left = (state == WRITE) & ~sel_q;
   assign en_right = (state == WRITE) & sel_q;
   assign data_to_save = (state == WRITE) ? data_q : 4'b0000;
   assign ack_a = (state == WRITE) & ~gnt;
   assign ack_b = (state == WRITE) & gnt;
   assign nack_a = (state == REJECT) & ~gnt;
   assign nack_b = (state == REJECT) & gnt;
   assign locked = (state == LOCKOUT);
endmodule

// File: tb/tb_register_access_arbiter.sv
// tb_register_access_arbiter: random requesters checked cycle-by-cycle against a transaction-level schedule model
module tb_register_access_arbiter;
   localparam int MAX_FAILS = 3;
   localparam int LOCK_CYCLES = 8;
   localparam int N = 4096;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [3:0] system_password = 4'hA;
   logic req [2];
   logic sel [2];
   logic [3:0] pass [2];
   logic [3:0] data [2];
   logic en_left, en_right, ack_a, ack_b, nack_a, nack_b, locked;
   logic [3:0] data_to_save;
   logic [10:0] out_v;
   logic [10:0] exp_v [N];
   int n_tests = 0, n_fail = 0;
   int e, next_free, pend_edge, m_fails;
   bit pend, ptr_b, p_who, p_sel, gen_on;
   bit act [2];
   bit granted [2];
   logic [3:0] p_pass, p_data;
   always #5 clock = ~clock;
   register_access_arbiter #(.MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)) dut (
      .clock(clock), .reset(reset), .system_password(system_password),
      .req_a(req[0]), .req_b(req[1]), .sel_a(sel[0]), .sel_b(sel[1]),
      .pass_a(pass[0]), .pass_b(pass[1]), .data_a(data[0]), .data_b(data[1]),
      .en_left(en_left), .en_right(en_right), .data_to_save(data_to_save),
      .ack_a(ack_a), .ack_b(ack_b), .nack_a(nack_a), .nack_b(nack_b), .locked(locked)
   );
   assign out_v = {en_left, en_right, data_to_save, ack_a, ack_b, nack_a, nack_b, locked};
   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, expv);
      end
   endtask
   task automatic model_reset();
      e = 0;
      next_free = 1;
      pend = 0;
      ptr_b = 0;
      m_fails = 0;
      for (int i = 0; i < N; i++) exp_v[i] = '0;
      for (int x = 0; x < 2; x++) begin
         act[x] = 0;
         granted[x] = 0;
      end
   endtask
   task automatic drive();
      if (gen_on && $urandom_range(15) == 0) system_password = 4'($urandom);
      for (int x = 0; x < 2; x++) begin
         if (granted[x] && (exp_v[e][4-x] || exp_v[e][2-x])) begin
            req[x] = 1'b0;
            granted[x] = 0;
            act[x] = 0;
         end else if (granted[x]) begin
            sel[x] = 1'($urandom);
            pass[x] = 4'($urandom);
            data[x] = 4'($urandom);
         end else if (!act[x] && gen_on && $urandom_range(2) == 0) begin
            act[x] = 1;
            req[x] = 1'b1;
            sel[x] = 1'($urandom);
            data[x] = 4'($urandom);
            pass[x] = $urandom_range(1) ? system_password : 4'($urandom);
         end
      end
   endtask
   task automatic plan();
      int t;
      t = e + 1;
      if (pend && t == pend_edge + 1) begin
         pend = 0;
         if (p_pass == system_password) begin
            m_fails = 0;
            exp_v[t][10] = !p_sel;
            exp_v[t][9] = p_sel;
            exp_v[t][8:5] = p_data;
            exp_v[t][4-p_who] = 1'b1;
            next_free = t + 2;
         end else begin
            m_fails++;
            exp_v[t][2-p_who] = 1'b1;
            next_free = t + 2;
            if (m_fails == MAX_FAILS) begin
               m_fails = 0;
               for (int i = 1; i <= LOCK_CYCLES; i++) exp_v[t+i][0] = 1'b1;
               next_free = t + 2 + LOCK_CYCLES;
            end
         end
      end
      if (!pend && t >= next_free && (req[0] || req[1])) begin
         p_who = req[1] && (!req[0] || ptr_b);
         p_sel = sel[p_who];
         p_pass = pass[p_who];
         p_data = data[p_who];
         pend = 1;
         pend_edge = t;
         ptr_b = !p_who;
         granted[p_who] = 1;
      end
   endtask
   task automatic step();
      @(posedge clock);
      e++;
      @(negedge clock);
      check($sformatf("cyc%0d", e), out_v, exp_v[e]);
   endtask
   initial begin
      for (int x = 0; x < 2; x++) begin
         req[x] = 1'b0;
         sel[x] = 1'b0;
         pass[x] = '0;
         data[x] = '0;
      end
      gen_on = 0;
      repeat (2) @(negedge clock);
      check("reset", out_v, '0);
      reset = 1'b0;
      model_reset();
      gen_on = 1;
      repeat (1500) begin
         drive();
         plan();
         step();
      end
      gen_on = 0;
      repeat (30) begin
         drive();
         plan();
         step();
      end
      req[0] = 1'b1;
      sel[0] = 1'b0;
      data[0] = 4'h5;
      pass[0] = system_password;
      act[0] = 1;
      plan();
      step();
      drive();
      plan();
      step();
      check("mid_wr", out_v, {2'b10, 4'h5, 5'b10000});
      reset = 1'b1;
      #1;
      check("rst_mid", out_v, '0);
      @(negedge clock);
      check("rst_hold", out_v, '0);
      reset = 1'b0;
      model_reset();
      for (int x = 0; x < 2; x++) begin
         req[x] = 1'b1;
         sel[x] = 1'(x);
         data[x] = 4'(x + 1);
         pass[x] = system_password;
         act[x] = 1;
      end
      repeat (12) begin
         drive();
         plan();
         step();
         if (e == 2) check("rst_first_a", out_v, {2'b10, 4'h1, 5'b10000});
         if (e == 5) check("rst_then_b", out_v, {2'b01, 4'h2, 5'b01000});
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
